// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_ctrl                                                 |
// | Brief    : Single-port access controller in front of the unified           |
// |            instruction/data memory. Arbitrates fetch and load/store        |
// |            requests onto one memory port, registers the returned word,     |
// |            acknowledges the requester and rejects out-of-range addresses.  |
// | Options  : MAC_WRITE_PROTECT_EN - when defined, stores below DATA_BASE are  |
// |            rejected (no write, data_ack + addr_err).                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_access_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int WDATA_W   = 8,
  parameter int RDATA_W   = 16,
  parameter int DEPTH     = 64,
  parameter int DATA_BASE = 56
) (
  input  logic               clk,
  input  logic               rst,
  // instruction fetch port
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ack,
  output logic [RDATA_W-1:0] instr_out,
  // load/store port
  input  logic               data_req,
  input  logic               data_we,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [WDATA_W-1:0] data_wdata,
  output logic               data_ack,
  output logic [RDATA_W-1:0] data_rdata,
  // status
  output logic               addr_err,
  output logic               busy,
  // memory port
  output logic [ADDR_W-1:0]  mem_A,
  output logic [WDATA_W-1:0] mem_WD,
  output logic               mem_WE,
  input  logic [RDATA_W-1:0] mem_out
);

  // One extra bit keeps the bound compares correct even when DEPTH equals 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_EXT     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] DATA_BASE_EXT = (ADDR_W+1)'(DATA_BASE);

  // Requester select encoding, shared by sel and last_grant.
  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t               state_q;
  logic                 last_grant_q;
  logic                 sel_q;
  logic                 store_q;
  logic                 err_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    mem_A_q;
  logic [WDATA_W-1:0]   mem_WD_q;
  logic                 fetch_ack_q;
  logic                 data_ack_q;
  logic                 addr_err_q;
  logic [RDATA_W-1:0]   instr_out_q;
  logic [RDATA_W-1:0]   data_rdata_q;

  // Grant decision for the current IDLE cycle, captured only on a grant.
  logic                 sel_d;
  logic [ADDR_W-1:0]    addr_d;
  logic                 store_d;
  logic                 in_range_d;
  logic                 below_base_d;
  logic                 protect_d;
  logic                 reject_d;
  logic                 we_d;

  // Arbitration and address qualification of the pending request.
  always_comb begin
    sel_d        = SEL_FETCH;
    addr_d       = '0;
    store_d      = 1'b0;
    in_range_d   = 1'b0;
    below_base_d = 1'b0;
    protect_d    = 1'b0;
    reject_d     = 1'b0;
    we_d         = 1'b0;

    // On a tie the requester that lost last time wins; a lone request always wins.
    if (fetch_req && data_req) begin
      sel_d = (last_grant_q == SEL_FETCH) ? SEL_DATA : SEL_FETCH;
    end else begin
      sel_d = data_req ? SEL_DATA : SEL_FETCH;
    end

    addr_d       = (sel_d == SEL_DATA) ? data_addr : fetch_addr;
    store_d      = (sel_d == SEL_DATA) && data_we;
    in_range_d   = ({1'b0, addr_d} < DEPTH_EXT);
    below_base_d = ({1'b0, addr_d} < DATA_BASE_EXT);

`ifdef MAC_WRITE_PROTECT_EN
    protect_d = store_d && below_base_d;
`else
    // Program region is writable; the base compare is kept but never gates a store.
    protect_d = store_d && below_base_d && 1'b0;
`endif

    reject_d = !in_range_d || protect_d;
    we_d     = store_d && !reject_d;
  end

  // Access sequencer: IDLE grants, ACCESS drives the memory and captures, RESP acknowledges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= SEL_FETCH;
      sel_q        <= SEL_FETCH;
      store_q      <= 1'b0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      mem_A_q      <= '0;
      mem_WD_q     <= '0;
      fetch_ack_q  <= 1'b0;
      data_ack_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      instr_out_q  <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          fetch_ack_q <= 1'b0;
          data_ack_q  <= 1'b0;
          addr_err_q  <= 1'b0;
          if (fetch_req || data_req) begin
            state_q      <= S_ACCESS;
            last_grant_q <= sel_d;
            sel_q        <= sel_d;
            store_q      <= store_d;
            err_q        <= reject_d;
            we_q         <= we_d;
            mem_A_q      <= addr_d;
            mem_WD_q     <= (sel_d == SEL_DATA) ? data_wdata : '0;
          end
        end

        S_ACCESS: begin
          state_q     <= S_RESP;
          we_q        <= 1'b0;
          mem_A_q     <= '0;
          mem_WD_q    <= '0;
          fetch_ack_q <= (sel_q == SEL_FETCH);
          data_ack_q  <= (sel_q == SEL_DATA);
          addr_err_q  <= err_q;
          // Rejected reads return zero; stores never touch the read registers.
          if (sel_q == SEL_FETCH) begin
            instr_out_q <= err_q ? '0 : mem_out;
          end else if (!store_q) begin
            data_rdata_q <= err_q ? '0 : mem_out;
          end
        end

        S_RESP: begin
          state_q     <= S_IDLE;
          fetch_ack_q <= 1'b0;
          data_ack_q  <= 1'b0;
          addr_err_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The write strobe is gated by reset directly so a reset landing in ACCESS cannot write.
  assign mem_WE     = we_q && !rst;
  assign mem_A      = mem_A_q;
  assign mem_WD     = mem_WD_q;
  assign fetch_ack  = fetch_ack_q;
  assign data_ack   = data_ack_q;
  assign addr_err   = addr_err_q;
  assign instr_out  = instr_out_q;
  assign data_rdata = data_rdata_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_access_ctrl                                              |
// | Brief    : Self-checking bench for mem_access_ctrl with a behavioural      |
// |            memory, a transaction-level reference model, directed cases     |
// |            and randomized traffic. Honours MAC_WRITE_PROTECT_EN.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ack;
  logic [15:0] instr_out;
  logic        data_req;
  logic        data_we;
  logic [7:0]  data_addr;
  logic [7:0]  data_wdata;
  logic        data_ack;
  logic [15:0] data_rdata;
  logic        addr_err;
  logic        busy;
  logic [7:0]  mem_A;
  logic [7:0]  mem_WD;
  logic        mem_WE;
  logic [15:0] mem_out;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  // Memory behind the controller (256 words so out-of-range addresses still read something).
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];

  // Reference model state at transaction level.
  bit          model_last_data;
  logic [15:0] model_instr;
  logic [15:0] model_rdata;

  mem_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .instr_out  (instr_out),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_ack   (data_ack),
    .data_rdata (data_rdata),
    .addr_err   (addr_err),
    .busy       (busy),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_out    (mem_out)
  );

  always #5 clk = ~clk;

  assign mem_out = mem[mem_A];

  always @(posedge clk) begin
    if (mem_WE) begin
      mem[mem_A] <= {8'h00, mem_WD};
      wr_count   <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_fack"},  32'(fetch_ack), 32'd0);
    chk({tag, "_dack"},  32'(data_ack),  32'd0);
    chk({tag, "_err"},   32'(addr_err),  32'd0);
    chk({tag, "_memA"},  32'(mem_A),     32'd0);
    chk({tag, "_memWD"}, 32'(mem_WD),    32'd0);
    chk({tag, "_memWE"}, 32'(mem_WE),    32'd0);
  endtask

  // One complete transaction; entered and left at a negedge while the DUT is idle.
  task automatic txn(input string tag, input logic f, input logic d, input logic we,
                     input logic [7:0] fa, input logic [7:0] da, input logic [7:0] wd);
    bit          win_data;
    logic [7:0]  a;
    bit          is_store;
    bit          rejected;
    bit          writes;
    int          wc0;
    logic [15:0] exp_instr;
    logic [15:0] exp_rdata;

    // Expected outcome from the access rules.
    win_data  = (f && d) ? !model_last_data : d;
    a         = win_data ? da : fa;
    is_store  = win_data && we;
    rejected  = (a >= 8'd64);
`ifdef MAC_WRITE_PROTECT_EN
    if (is_store && a < 8'd56) rejected = 1'b1;
`endif
    writes    = is_store && !rejected;
    exp_instr = model_instr;
    exp_rdata = model_rdata;
    if (!win_data)     exp_instr = rejected ? 16'h0000 : ref_mem[a];
    else if (!we)      exp_rdata = rejected ? 16'h0000 : ref_mem[a];

    fetch_req  = f;
    data_req   = d;
    data_we    = we;
    fetch_addr = fa;
    data_addr  = da;
    data_wdata = wd;
    wc0        = wr_count;

    @(posedge clk); @(negedge clk);
    chk({tag, "_acc_busy"}, 32'(busy),      32'd1);
    chk({tag, "_acc_fack"}, 32'(fetch_ack), 32'd0);
    chk({tag, "_acc_dack"}, 32'(data_ack),  32'd0);
    chk({tag, "_acc_memA"}, 32'(mem_A),     32'(a));
    chk({tag, "_acc_WE"},   32'(mem_WE),    32'(writes));
    if (is_store) chk({tag, "_acc_WD"}, 32'(mem_WD), 32'(wd));

    // Inputs moving outside IDLE must not disturb the access in flight.
    fetch_addr = 8'($urandom);
    data_addr  = 8'($urandom);
    data_wdata = 8'($urandom);
    data_we    = 1'($urandom);

    @(posedge clk); @(negedge clk);
    if (writes) ref_mem[a] = {8'h00, wd};
    model_last_data = win_data;
    model_instr     = exp_instr;
    model_rdata     = exp_rdata;
    chk({tag, "_rsp_fack"},  32'(fetch_ack),     32'(!win_data));
    chk({tag, "_rsp_dack"},  32'(data_ack),      32'(win_data));
    chk({tag, "_rsp_err"},   32'(addr_err),      32'(rejected));
    chk({tag, "_rsp_instr"}, 32'(instr_out),     32'(exp_instr));
    chk({tag, "_rsp_rdata"}, 32'(data_rdata),    32'(exp_rdata));
    chk({tag, "_rsp_busy"},  32'(busy),          32'd1);
    chk({tag, "_rsp_WE"},    32'(mem_WE),        32'd0);
    chk({tag, "_rsp_memA"},  32'(mem_A),         32'd0);
    chk({tag, "_writes"},    32'(wr_count-wc0),  32'(writes));
    chk({tag, "_memword"},   32'(mem[a]),        32'(ref_mem[a]));

    fetch_req = 1'b0;
    data_req  = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_idle({tag, "_idle"});
  endtask

  initial begin
    int          wc0;
    logic [7:0]  ra;
    logic [7:0]  rb;
    int          r;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'($urandom) | 16'h0100;
      ref_mem[i] = mem[i];
    end
    mem[0]     = 16'hC000;
    ref_mem[0] = 16'hC000;

    rst = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0;
    model_last_data = 1'b0; model_instr = '0; model_rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset_instr", 32'(instr_out),  32'd0);
    chk("reset_rdata", 32'(data_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch of word 0.
    txn("fetch0", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("fetch0_nowrite", 32'(wr_count), 32'd0);

    // Store then load at the first data word.
    txn("st38", 1'b0, 1'b1, 1'b1, 8'h00, 8'h38, 8'h14);
    txn("ld38", 1'b0, 1'b1, 1'b0, 8'h00, 8'h38, 8'h00);
    chk("ld38_val", 32'(data_rdata), 32'h0014);

    // Ties alternate, data first after reset.
    txn("tie1", 1'b1, 1'b1, 1'b0, 8'h01, 8'h39, 8'h00);
    txn("tie2", 1'b1, 1'b1, 1'b0, 8'h02, 8'h39, 8'h00);
    txn("tie3", 1'b1, 1'b1, 1'b0, 8'h03, 8'h3A, 8'h00);

    // Out-of-range load and store.
    txn("ld40", 1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 8'h00);
    txn("stFF", 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hAB);
    txn("fetch80", 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00);

    // Reset landing in the ACCESS cycle of a store.
    wc0        = wr_count;
    data_req   = 1'b1; data_we = 1'b1; data_addr = 8'h3A; data_wdata = 8'h5A;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_WE", 32'(mem_WE), 32'd0);
    data_req = 1'b0;
    @(posedge clk); @(negedge clk);
    model_last_data = 1'b0; model_instr = '0; model_rdata = '0;
    chk_idle("rstmid");
    chk("rstmid_instr",  32'(instr_out),     32'd0);
    chk("rstmid_rdata",  32'(data_rdata),    32'd0);
    chk("rstmid_writes", 32'(wr_count-wc0),  32'd0);
    chk("rstmid_word",   32'(mem[8'h3A]),    32'(ref_mem[8'h3A]));
    rst = 1'b0;
    @(negedge clk);
    txn("postrst_tie", 1'b1, 1'b1, 1'b0, 8'h04, 8'h3A, 8'h00);

    // Program-region and data-region stores.
    txn("st05", 1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 8'hFF);
    txn("st3B", 1'b0, 1'b1, 1'b1, 8'h00, 8'h3B, 8'h77);
    txn("fe05", 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 8'h00);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(1, 3);
      ra = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
      rb = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
      txn("rand", r[0], r[1], 1'($urandom), ra, rb, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
